// File: rtl/ecall_sequencer_pkg.sv
// Shared constants, state/op enumerations and syscall decode for the ecall sequencer.
package ecall_pkg;

  localparam logic [31:0] ECALL_INST   = 32'h0000_0073;
  localparam logic [31:0] A7_PRINT_INT = 32'd1;
  localparam logic [31:0] A7_READ_INT  = 32'd5;
  localparam logic [31:0] A7_EXIT      = 32'd10;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    DRAIN        = 3'd1,
    DISPATCH     = 3'd2,
    WAIT_PRESS   = 3'd3,
    WAIT_RELEASE = 3'd4,
    COMMIT       = 3'd5,
    RESUME       = 3'd6,
    HALT         = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_PRINT = 2'd1,
    OP_READ  = 2'd2,
    OP_EXIT  = 2'd3
  } op_t;

  function automatic op_t decode_op(input logic [31:0] a7);
    op_t op;
    case (a7)
      A7_PRINT_INT: op = OP_PRINT;
      A7_READ_INT:  op = OP_READ;
      A7_EXIT:      op = OP_EXIT;
      default:      op = OP_NONE;
    endcase
    return op;
  endfunction

  function automatic logic is_ecall(input logic [31:0] inst);
    return (inst == ECALL_INST);
  endfunction

endpackage

// File: rtl/ecall_sequencer_debouncer.sv
// Confirm-button conditioning: 2-flop synchronizer plus a run-length counter that
// accepts a press/release once the synced level has held for DEBOUNCE_CYCLES cycles.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic raw,
  output logic press_acc,
  output logic release_acc
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] count;
  logic [CW-1:0] run_len;
  logic          accept;

  // two-stage synchronizer for the asynchronous push-button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // length of the current stable run including this cycle; a level change restarts at one
  always_comb begin
    if ((count != '0) && (sync2 == level)) begin
      run_len = count + ONE;
    end else begin
      run_len = ONE;
    end
  end

  // run-length state; cleared whenever the sequencer is not waiting on the button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      level <= 1'b0;
    end else if (!enable) begin
      count <= '0;
      level <= sync2;
    end else begin
      level <= sync2;
      count <= (run_len > TARGET) ? TARGET : run_len;
    end
  end

  // saturation past TARGET keeps each accepted level to a single pulse
  assign accept      = enable && (run_len == TARGET);
  assign press_acc   = accept && sync2;
  assign release_acc = accept && !sync2;

endmodule

// File: rtl/ecall_sequencer.sv
// Stalls fetch on an ecall, drains the pipeline, then services print/read/exit
// syscalls selected by a7 using the debounced confirm button.
module ecall_sequencer
  import ecall_pkg::*;
#(
  parameter int DRAIN_CYCLES    = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] a7,
  input  logic [31:0] a0,
  input  logic        confirm,
  input  logic [7:0]  num_in,
  output logic        stall,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic        disp_load,
  output logic [31:0] disp_data,
  output logic        halted,
  output logic [2:0]  state_dbg
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  state_t          state;
  op_t             op_r;
  op_t             dispatch_op;
  logic [DCW-1:0]  drain_cnt;
  logic [31:0]     disp_data_r;
  logic [31:0]     wr_data_r;
  logic            dbnc_en;
  logic            press_acc;
  logic            release_acc;
  logic            dispatch_print;

  assign dbnc_en = (state == WAIT_PRESS) || (state == WAIT_RELEASE);

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .rst        (rst),
    .enable     (dbnc_en),
    .raw        (confirm),
    .press_acc  (press_acc),
    .release_acc(release_acc)
  );

  // syscall decode is only meaningful in DISPATCH; afterwards op_r is authoritative
  always_comb begin
    dispatch_op    = decode_op(a7);
    dispatch_print = (state == DISPATCH) && (dispatch_op == OP_PRINT);
  end

  // sequencer FSM together with the op, display and read-data holding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_r        <= OP_NONE;
      drain_cnt   <= '0;
      disp_data_r <= 32'h0000_0000;
      wr_data_r   <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (is_ecall(inst)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= DISPATCH;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        DISPATCH: begin
          op_r <= dispatch_op;
          case (dispatch_op)
            OP_PRINT: begin
              disp_data_r <= a0;
              state       <= WAIT_PRESS;
            end
            OP_READ:  state <= WAIT_PRESS;
            OP_EXIT:  state <= HALT;
            default:  state <= RESUME;
          endcase
        end
        WAIT_PRESS: begin
          if (press_acc) begin
            state <= WAIT_RELEASE;
            if (op_r == OP_READ) begin
              wr_data_r <= {24'h00_0000, num_in};
            end
          end else begin
            state <= WAIT_PRESS;
          end
        end
        WAIT_RELEASE: begin
          if (release_acc) begin
            state <= (op_r == OP_READ) ? COMMIT : RESUME;
          end else begin
            state <= WAIT_RELEASE;
          end
        end
        COMMIT: state <= RESUME;
        // fetch advances past the ecall this cycle, so detection is not re-armed here
        RESUME: begin
          state <= IDLE;
          op_r  <= OP_NONE;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // the IDLE term holds the PC on the very cycle the ecall is first seen
  always_comb begin
    if (state == IDLE) begin
      stall = is_ecall(inst);
    end else begin
      stall = (state != RESUME);
    end
  end

  assign wr_en     = (state == COMMIT);
  assign wr_data   = wr_data_r;
  assign disp_load = dispatch_print;
  assign disp_data = dispatch_print ? a0 : disp_data_r;
  assign halted    = (state == HALT);
  assign state_dbg = state;

endmodule

// File: tb/tb_ecall_sequencer.sv
// Self-checking bench for ecall_sequencer: directed and randomized ecalls checked
// against an event-time model derived from the syscall and debounce rules.
module tb_ecall_sequencer;

  localparam int DRAIN = 4;
  localparam int DEB   = 16;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst = NOP;
  logic [31:0] a7 = 32'h0;
  logic [31:0] a0 = 32'h0;
  logic        confirm = 1'b0;
  logic [7:0]  num_in = 8'h0;
  logic        stall;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        disp_load;
  logic [31:0] disp_data;
  logic        halted;
  logic [2:0]  state_dbg;

  ecall_sequencer #(.DRAIN_CYCLES(DRAIN), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .inst(inst), .a7(a7), .a0(a0), .confirm(confirm),
    .num_in(num_in), .stall(stall), .wr_en(wr_en), .wr_data(wr_data),
    .disp_load(disp_load), .disp_data(disp_data), .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] last_disp = 32'h0;
  logic [31:0] last_wr = 32'h0;
  bit          raw_hist [0:59999];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // synced button level seen by the debounce counter in cycle c
  function automatic bit synced(input int c);
    return (c >= 2) ? raw_hist[c-2] : 1'b0;
  endfunction

  // true when the synced level has been lvl for DEB cycles ending at c, all at or after w
  function automatic bit stable(input int c, input bit lvl, input int w);
    if (c - (DEB - 1) < w) return 1'b0;
    for (int k = c - DEB + 1; k <= c; k++) begin
      if (synced(k) != lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input logic [31:0] i_inst, input logic [31:0] i_a7, input logic [31:0] i_a0,
                      input logic i_conf, input logic [7:0] i_num);
    @(posedge clk);
    cyc++;
    #1;
    inst = i_inst; a7 = i_a7; a0 = i_a0; confirm = i_conf; num_in = i_num;
    raw_hist[cyc] = i_conf;
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_disp_load"}, 32'(disp_load), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_disp_data"}, disp_data, 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    #1;
    inst = NOP; confirm = 1'b0; rst = 1'b1;
    #1;
    check_zero(tag);
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #1 rst = 1'b0;
    #1;
    last_wr = 32'h0;
    last_disp = 32'h0;
  endtask

  task automatic idle(input int n, input logic [31:0] iv);
    for (int k = 0; k < n; k++) begin
      step(iv, $urandom, $urandom, 1'($urandom_range(0, 1)), 8'($urandom));
      check("idle_stall", 32'(stall), 32'd0);
      check("idle_wr_en", 32'(wr_en), 32'd0);
      check("idle_disp_load", 32'(disp_load), 32'd0);
      check("idle_halted", 32'(halted), 32'd0);
      check("idle_state", 32'(state_dbg), 32'd0);
      check("idle_wr_data", wr_data, last_wr);
      check("idle_disp_data", disp_data, last_disp);
    end
  endtask

  // one ecall: confirm waveform after dispatch = tog cycles toggling every 5, d0 low,
  // b1 random, h high, b2 random, then low
  task automatic run_ecall(input logic [31:0] a7v, input logic [31:0] a0v, input logic [7:0] numv,
                           input int tog, input int d0, input int b1, input int h, input int b2,
                           input bit abort);
    int tdet, tdisp, p, rl, res, c, o;
    bit is_print, is_read, is_exit, done, aborted, rv;
    logic [31:0] inst_cur, a7d, a0d, exp_disp, exp_wr;
    is_print = (a7v == 32'd1);
    is_read  = (a7v == 32'd5);
    is_exit  = (a7v == 32'd10);
    tdet  = cyc + 1;
    tdisp = tdet + 1 + DRAIN;
    p = -1; rl = -1;
    res = (is_print || is_read || is_exit) ? -1 : tdisp + 1;
    inst_cur = ECALL; done = 1'b0; aborted = 1'b0;
    for (int k = 0; k < 1200 && !done; k++) begin
      c = cyc + 1;
      o = c - (tdisp + 1);
      if (o < 0) rv = 1'b0;
      else if (o < tog) rv = ((o / 5) % 2) == 1;
      else if (o < tog + d0) rv = 1'b0;
      else if (o < tog + d0 + b1) rv = 1'($urandom_range(0, 1));
      else if (o < tog + d0 + b1 + h) rv = 1'b1;
      else if (o < tog + d0 + b1 + h + b2) rv = 1'($urandom_range(0, 1));
      else rv = 1'b0;
      a7d = (c <= tdisp) ? a7v : $urandom;
      a0d = (c <= tdisp) ? a0v : $urandom;
      step(inst_cur, a7d, a0d, rv, numv);
      if ((is_print || is_read) && p < 0 && c > tdisp && stable(c, 1'b1, tdisp + 1)) p = c;
      else if (p >= 0 && rl < 0 && stable(c, 1'b0, p + 1)) begin
        rl = c;
        res = is_read ? c + 2 : c + 1;
      end
      exp_disp = (is_print && c >= tdisp) ? a0v : last_disp;
      exp_wr   = (is_read && p >= 0 && c > p) ? {24'h0, numv} : last_wr;
      check("stall", 32'(stall), 32'(is_exit || res < 0 || c < res));
      check("disp_load", 32'(disp_load), 32'(is_print && c == tdisp));
      check("wr_en", 32'(wr_en), 32'(is_read && res >= 0 && c == res - 1));
      check("halted", 32'(halted), 32'(is_exit && c > tdisp));
      check("disp_data", disp_data, exp_disp);
      check("wr_data", wr_data, exp_wr);
      if ((is_print || is_read) && p < 0 && c > tdisp) check("state_wait_press", 32'(state_dbg), 32'd3);
      if (res >= 0 && c == res) inst_cur = NOP;
      if (res >= 0 && c == res + 1) begin
        check("back_to_idle", 32'(state_dbg), 32'd0);
        done = 1'b1;
      end
      if (is_exit && c == tdisp + 1000) done = 1'b1;
      if (abort && p >= 0 && rl < 0 && c == p + 5) begin
        do_reset("abort");
        aborted = 1'b1;
        done = 1'b1;
      end
    end
    check("completion", 32'(done), 32'd1);
    if (!aborted && is_print) last_disp = a0v;
    if (!aborted && is_read && p >= 0) last_wr = {24'h0, numv};
  endtask

  initial begin
    logic [31:0] ra7;
    #1 rst = 1'b1;
    #1 check_zero("reset");
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #1 rst = 1'b0;
    #1;
    idle(5, NOP);
    idle(10, 32'h0010_0073);
    idle(10, 32'h3020_0073);
    run_ecall(32'd1, 32'h1234_5678, 8'h00, 0, 0, 0, 30, 0, 1'b0);
    idle(3, NOP);
    run_ecall(32'd5, 32'h0000_0000, 8'hA5, 0, 3, 0, 25, 0, 1'b0);
    idle(3, NOP);
    run_ecall(32'd5, 32'h0000_0000, 8'h3C, 200, 2, 0, 25, 4, 1'b0);
    idle(3, NOP);
    run_ecall(32'd7, 32'hDEAD_BEEF, 8'h11, 0, 0, 0, 20, 0, 1'b0);
    idle(5, NOP);
    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 2))
        0: ra7 = 32'd1;
        1: ra7 = 32'd5;
        default: begin
          ra7 = $urandom;
          if (ra7 == 32'd1 || ra7 == 32'd5 || ra7 == 32'd10) ra7 = 32'd0;
        end
      endcase
      run_ecall(ra7, $urandom, 8'($urandom), 5 * $urandom_range(0, 6), $urandom_range(0, 10),
                $urandom_range(0, 8), $urandom_range(18, 40), $urandom_range(0, 8), 1'b0);
      idle($urandom_range(1, 4), NOP);
    end
    run_ecall(32'd5, 32'h0, 8'h77, 0, 2, 0, 40, 0, 1'b1);
    idle(30, NOP);
    run_ecall(32'd10, 32'h0, 8'h00, 0, 2, 0, 40, 0, 1'b0);
    do_reset("exit_reset");
    idle(10, NOP);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ecall_sequencer.md
Name: ecall_sequencer

Overview:
- Controller that sequences the CPU pipeline around an `ecall` instruction.
- It detects `ecall` at fetch, stalls the front end, and waits for older instructions to drain. It then services the syscall selected by a7: print (load the 7-seg display), read (8-bit switches into a0, gated by the confirm button), or exit (halt).
- It sits beside IFetch/Registers in Top, between the board I/O (confirm, switches) and the register-file write port.

Parameters:
- DRAIN_CYCLES, 4, cycles waited after detection so in-flight instructions write back before a7/a0 are sampled.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles needed to accept a confirm press or release.

Ports:
- clk  in  1  CPU clock
- rst  in  1  asynchronous, active-high reset
- inst  in  32  instruction currently at fetch
- a7  in  32  register x17 value
- a0  in  32  register x10 value
- confirm  in  1  raw push-button, asynchronous to clk
- num_in  in  8  switch input
- stall  out  1  freezes PC/fetch when high
- wr_en  out  1  one-cycle pulse: write wr_data into a0
- wr_data  out  32  data for a0
- disp_load  out  1  one-cycle pulse: display latches disp_data
- disp_data  out  32  value to display
- halted  out  1  program exited
- state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - stall, wr_en, disp_load, halted = 0; wr_data, disp_data = 0.
  - Debouncer counters and synchronizer cleared.
  - Asserting rst in any state, including HALT or mid-wait, aborts the operation immediately.
- ECALL encoding is 32'h00000073. The match is exact; other SYSTEM opcodes are ignored.
- stall = 1 when state != IDLE and state != RESUME. It is also 1 combinationally in IDLE when inst == ECALL, so the PC never advances past a detected ecall.
- States and transitions:
  - IDLE: inst == ECALL -> DRAIN, drain counter = 0.
  - DRAIN: counter increments each cycle; when it reaches DRAIN_CYCLES-1 -> DISPATCH.
  - DISPATCH (one cycle): sample a7.
    - a7 == 1: disp_data <= a0, disp_load pulse in the same cycle, then -> WAIT_PRESS.
    - a7 == 5: -> WAIT_PRESS.
    - a7 == 10: -> HALT.
    - Any other value: -> RESUME (no-op).
  - WAIT_PRESS: on debounced press -> WAIT_RELEASE. For a7 == 5, wr_data <= {24'b0, num_in}, captured at the press acceptance cycle.
  - WAIT_RELEASE: on debounced release -> COMMIT if the op is read, else -> RESUME.
  - COMMIT (one cycle): wr_en = 1 -> RESUME.
  - RESUME (one cycle): stall = 0 and ecall detection masked, so fetch advances past the ecall -> IDLE.
  - HALT: stall = 1, halted = 1, confirm ignored; leaves only on reset.
- Timing: detection at cycle T; DISPATCH at T+1+DRAIN_CYCLES; RESUME exactly one cycle after COMMIT or after the release is accepted.
- The op code (print/read) is held in a register from DISPATCH until IDLE. a7/a0 changes after DISPATCH have no effect.
- Debounce:
  - confirm passes through a 2-flop synchronizer.
  - Press is accepted when the synced level has been 1 for DEBOUNCE_CYCLES consecutive cycles; any 0 restarts the count. Release is the same with level 0.
  - Counters run only in WAIT_PRESS/WAIT_RELEASE and clear on entering those states.
  - A button already held when WAIT_PRESS is entered counts as a press after DEBOUNCE_CYCLES.
- Output rules: wr_en and disp_load are never high in the same cycle, and each pulses at most once per ecall. disp_data and wr_data hold their last value between ecalls.

Decomposition:
- Package ecall_pkg: ECALL_INST constant, A7_PRINT_INT=1, A7_READ_INT=5, A7_EXIT=10, and the state enumeration (IDLE, DRAIN, DISPATCH, WAIT_PRESS, WAIT_RELEASE, COMMIT, RESUME, HALT).
- One sub-module: button_debouncer (synchronizer plus stable-level counter).
  - Inputs: clk, rst, enable, raw.
  - Outputs: press_acc, release_acc pulses.

Test Plan:
- Print: a7=1, a0=32'h12345678, inst=ECALL at T.
  - stall is high from T.
  - disp_load pulses at T+5 (default params) with disp_data=32'h12345678.
  - Hold confirm 30 cycles, then release: stall low for exactly one cycle (RESUME), then IDLE.
- Read: a7=5, num_in=8'hA5, press then release.
  - wr_en is high for exactly one cycle, DEBOUNCE_CYCLES+2 cycles after release starts, with wr_data=32'h000000A5.
  - disp_load never pulses.
- Bounce: in WAIT_PRESS, toggle confirm every 5 cycles for 200 cycles -> state stays WAIT_PRESS and wr_en stays 0.
- Exit: a7=10 -> halted=1 and stall=1 persist for 1000 cycles despite confirm presses; rst pulse clears both asynchronously.
- Unknown op: a7=7 -> no wr_en/disp_load; stall high for T..T+5 (default params), low at T+6 (RESUME); the ecall is not re-detected.
- Reset mid-op: assert rst during WAIT_RELEASE of a read -> all outputs 0 before the next clk edge; no wr_en after rst is released.
